// File: rtl/kernel_mem_shell_pkg.sv
// Shared types and defaults for the kernel memory shell.
package kernel_shell_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RUN,
      ST_WRITE,
      ST_DONE
   } shell_state_t;

   localparam int DEF_ADDR_WID  = 14;
   localparam int DEF_DATA_WID  = 32;
   localparam int DEF_HADDR_WID = 64;

   // Value latched into error when a job is rejected for bad lengths.
   localparam logic ERR_BAD_LEN = 1'b1;

endpackage

// File: rtl/kernel_mem_shell_if.sv
// Host memory bus between the shell (master) and host memory (slave).
interface kernel_mem_shell_if
   import kernel_shell_pkg::*;
#(
   parameter int HADDR_WID = DEF_HADDR_WID,
   parameter int DATA_WID  = DEF_DATA_WID
) ();

   logic                 read_enable;
   logic [HADDR_WID-1:0] read_addr;
   logic                 read_ready;
   logic [DATA_WID-1:0]  read_data;
   logic                 finish_read;
   logic                 write_enable;
   logic [HADDR_WID-1:0] write_addr;
   logic [DATA_WID-1:0]  write_data;
   logic                 write_ready;
   logic                 finish_write;

   modport master (
      output read_enable, read_addr, finish_read,
      output write_enable, write_addr, write_data, finish_write,
      input  read_ready, read_data, write_ready
   );

   modport slave (
      input  read_enable, read_addr, finish_read,
      input  write_enable, write_addr, write_data, finish_write,
      output read_ready, read_data, write_ready
   );

endinterface

// File: rtl/kernel_mem_shell_dpram.sv
// Two-port on-chip buffer: registered read-first reads, port 1 wins on same-address writes.
module shell_dpram #(
   parameter int ADDR_WID = 14,
   parameter int DATA_WID = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce0_i,
   input  logic                we0_i,
   input  logic [ADDR_WID-1:0] addr0_i,
   input  logic [DATA_WID-1:0] d0_i,
   output logic [DATA_WID-1:0] q0_o,
   input  logic                ce1_i,
   input  logic                we1_i,
   input  logic [ADDR_WID-1:0] addr1_i,
   input  logic [DATA_WID-1:0] d1_i,
   output logic [DATA_WID-1:0] q1_o
);

   logic [DATA_WID-1:0] mem [0:(1 << ADDR_WID)-1];
   logic [DATA_WID-1:0] q0_q;
   logic [DATA_WID-1:0] q1_q;

   // Port 1 is written last so its value survives a same-address collision.
   always_ff @(posedge clk) begin
      if (ce0_i && we0_i) mem[addr0_i] <= d0_i;
      if (ce1_i && we1_i) mem[addr1_i] <= d1_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q0_q <= '0;
         q1_q <= '0;
      end else begin
         if (ce0_i && !we0_i) q0_q <= mem[addr0_i];
         if (ce1_i && !we1_i) q1_q <= mem[addr1_i];
      end
   end

   assign q0_o = q0_q;
   assign q1_o = q1_q;

endmodule

// File: rtl/kernel_mem_shell.sv
// Host-side shell for one HLS kernel: bulk read, run, bulk write-back, done.
// Optional per-state cycle counters are built when KERNEL_SHELL_PERF_EN is defined.
module kernel_mem_shell
   import kernel_shell_pkg::*;
#(
   parameter int ADDR_WID  = DEF_ADDR_WID,
   parameter int DATA_WID  = DEF_DATA_WID,
   parameter int HADDR_WID = DEF_HADDR_WID
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [HADDR_WID-1:0] read_base,
   input  logic [HADDR_WID-1:0] write_base,
   input  logic [HADDR_WID-1:0] num_read,
   input  logic [HADDR_WID-1:0] num_write,
   input  logic [HADDR_WID-1:0] stride,
   kernel_mem_shell_if.master   host,
   output logic                 k_start,
   input  logic                 k_done,
   input  logic [DATA_WID-1:0]  k_ret,
   input  logic [ADDR_WID-1:0]  k_addr0,
   input  logic [ADDR_WID-1:0]  k_addr1,
   input  logic                 k_ce0,
   input  logic                 k_ce1,
   input  logic                 k_we0,
   input  logic                 k_we1,
   input  logic [DATA_WID-1:0]  k_d0,
   input  logic [DATA_WID-1:0]  k_d1,
   output logic [DATA_WID-1:0]  k_q0,
   output logic [DATA_WID-1:0]  k_q1,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [DATA_WID-1:0]  returnvalue
`ifdef KERNEL_SHELL_PERF_EN
   ,
   output logic [HADDR_WID-1:0] cyc_read,
   output logic [HADDR_WID-1:0] cyc_run,
   output logic [HADDR_WID-1:0] cyc_write
`endif
);

   typedef logic [ADDR_WID:0] cnt_t;
   localparam cnt_t                 CNT_ONE = cnt_t'(1);
   localparam logic [HADDR_WID-1:0] DEPTH   = HADDR_WID'(1) << ADDR_WID;

   shell_state_t         state_q, state_d;
   logic [HADDR_WID-1:0] raddr_q, raddr_d;
   logic [HADDR_WID-1:0] waddr_q, waddr_d;
   cnt_t                 rcnt_q, rcnt_d;
   cnt_t                 wcnt_q, wcnt_d;
   cnt_t                 nread_q, nread_d;
   cnt_t                 nwrite_q, nwrite_d;
   logic                 ren_q, ren_d;
   logic                 wen_q, wen_d;
   logic                 fin_rd_q, fin_rd_d;
   logic                 fin_wr_q, fin_wr_d;
   logic                 kstart_q, kstart_d;
   logic                 err_q, err_d;
   logic [DATA_WID-1:0]  ret_q, ret_d;

   logic                 start_ok, bad_len, last_rd, last_wr;
   cnt_t                 wnext;

   logic                 p0_ce, p0_we, p1_ce, p1_we;
   logic [ADDR_WID-1:0]  p0_addr;
   logic [DATA_WID-1:0]  p0_d, q0, q1;

   assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign bad_len  = (num_read == '0) || (num_read > DEPTH) || (num_write > DEPTH);
   assign last_rd  = (rcnt_q == nread_q - CNT_ONE);
   assign last_wr  = (wcnt_q == nwrite_q - CNT_ONE);
   // Prefetch address for write-back: the next word once the current one is taken.
   assign wnext    = wcnt_q + cnt_t'(host.write_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         raddr_q  <= '0;
         waddr_q  <= '0;
         rcnt_q   <= '0;
         wcnt_q   <= '0;
         nread_q  <= '0;
         nwrite_q <= '0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         fin_rd_q <= 1'b0;
         fin_wr_q <= 1'b0;
         kstart_q <= 1'b0;
         err_q    <= 1'b0;
         ret_q    <= '0;
      end else begin
         state_q  <= state_d;
         raddr_q  <= raddr_d;
         waddr_q  <= waddr_d;
         rcnt_q   <= rcnt_d;
         wcnt_q   <= wcnt_d;
         nread_q  <= nread_d;
         nwrite_q <= nwrite_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         fin_rd_q <= fin_rd_d;
         fin_wr_q <= fin_wr_d;
         kstart_q <= kstart_d;
         err_q    <= err_d;
         ret_q    <= ret_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      rcnt_d   = rcnt_q;
      wcnt_d   = wcnt_q;
      nread_d  = nread_q;
      nwrite_d = nwrite_q;
      ren_d    = ren_q;
      wen_d    = wen_q;
      fin_rd_d = 1'b0;
      fin_wr_d = 1'b0;
      kstart_d = 1'b0;
      err_d    = err_q;
      ret_d    = ret_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (bad_len) begin
                  err_d   = ERR_BAD_LEN;
                  state_d = ST_DONE;
               end else begin
                  err_d    = 1'b0;
                  ret_d    = '0;
                  raddr_d  = read_base;
                  rcnt_d   = '0;
                  wcnt_d   = '0;
                  nread_d  = num_read[ADDR_WID:0];
                  nwrite_d = num_write[ADDR_WID:0];
                  ren_d    = 1'b1;
                  state_d  = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (host.read_ready) begin
               raddr_d = raddr_q + stride;
               rcnt_d  = rcnt_q + CNT_ONE;
               if (last_rd) begin
                  ren_d    = 1'b0;
                  kstart_d = 1'b1;
                  state_d  = ST_RUN;
               end else begin
                  fin_rd_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (k_done) begin
               ret_d = k_ret;
               if (nwrite_q != '0) begin
                  waddr_d = write_base;
                  wcnt_d  = '0;
                  wen_d   = 1'b1;
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
            if (host.write_ready) begin
               waddr_d = waddr_q + stride;
               wcnt_d  = wcnt_q + CNT_ONE;
               if (last_wr) begin
                  wen_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  fin_wr_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Port 0 belongs to the host path outside RUN; on k_done it prefetches word 0.
   always_comb begin
      p0_ce   = 1'b0;
      p0_we   = 1'b0;
      p0_addr = '0;
      p0_d    = '0;
      case (state_q)
         ST_READ: begin
            p0_ce   = host.read_ready;
            p0_we   = 1'b1;
            p0_addr = rcnt_q[ADDR_WID-1:0];
            p0_d    = host.read_data;
         end
         ST_WRITE: begin
            p0_ce   = 1'b1;
            p0_addr = wnext[ADDR_WID-1:0];
         end
         ST_RUN: begin
            if (k_done) begin
               p0_ce = 1'b1;
            end else begin
               p0_ce   = k_ce0;
               p0_we   = k_we0;
               p0_addr = k_addr0;
               p0_d    = k_d0;
            end
         end
         default: ;
      endcase
   end

   assign p1_ce = k_ce1 && (state_q == ST_RUN);
   assign p1_we = k_we1;

   shell_dpram #(
      .ADDR_WID (ADDR_WID),
      .DATA_WID (DATA_WID)
   ) u_dpram (
      .clk     (clk),
      .reset   (reset),
      .ce0_i   (p0_ce),
      .we0_i   (p0_we),
      .addr0_i (p0_addr),
      .d0_i    (p0_d),
      .q0_o    (q0),
      .ce1_i   (p1_ce),
      .we1_i   (p1_we),
      .addr1_i (k_addr1),
      .d1_i    (k_d1),
      .q1_o    (q1)
   );

   assign host.read_enable  = ren_q;
   assign host.read_addr    = raddr_q;
   assign host.finish_read  = fin_rd_q;
   assign host.write_enable = wen_q;
   assign host.write_addr   = waddr_q;
   assign host.write_data   = q0;
   assign host.finish_write = fin_wr_q;
   assign k_start           = kstart_q;
   assign k_q0              = q0;
   assign k_q1              = q1;
   assign busy              = (state_q == ST_READ) || (state_q == ST_RUN) || (state_q == ST_WRITE);
   assign done              = (state_q == ST_DONE);
   assign error             = err_q;
   assign returnvalue       = ret_q;

`ifdef KERNEL_SHELL_PERF_EN
   logic [HADDR_WID-1:0] cyc_read_q, cyc_run_q, cyc_write_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_read_q  <= '0;
         cyc_run_q   <= '0;
         cyc_write_q <= '0;
      end else if (start_ok) begin
         cyc_read_q  <= '0;
         cyc_run_q   <= '0;
         cyc_write_q <= '0;
      end else begin
         if (state_q == ST_READ)  cyc_read_q  <= cyc_read_q + 1'b1;
         if (state_q == ST_RUN)   cyc_run_q   <= cyc_run_q + 1'b1;
         if (state_q == ST_WRITE) cyc_write_q <= cyc_write_q + 1'b1;
      end
   end

   assign cyc_read  = cyc_read_q;
   assign cyc_run   = cyc_run_q;
   assign cyc_write = cyc_write_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_kernel_mem_shell.sv
// Directed bench for kernel_mem_shell: host read/write models, kernel stub, write-back scoreboard.
module tb_kernel_mem_shell;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int HW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [HW-1:0] read_base, write_base, num_read, num_write, stride;
   logic          k_start, k_done;
   logic [DW-1:0] k_ret;
   logic [AW-1:0] k_addr0, k_addr1;
   logic          k_ce0, k_ce1, k_we0, k_we1;
   logic [DW-1:0] k_d0, k_d1, k_q0, k_q1;
   logic          busy, done, error;
   logic [DW-1:0] returnvalue;
`ifdef KERNEL_SHELL_PERF_EN
   logic [HW-1:0] cyc_read, cyc_run, cyc_write;
`endif

   kernel_mem_shell_if #(.HADDR_WID(HW), .DATA_WID(DW)) host ();

   kernel_mem_shell #(
      .ADDR_WID  (AW),
      .DATA_WID  (DW),
      .HADDR_WID (HW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .read_base   (read_base),
      .write_base  (write_base),
      .num_read    (num_read),
      .num_write   (num_write),
      .stride      (stride),
      .host        (host),
      .k_start     (k_start),
      .k_done      (k_done),
      .k_ret       (k_ret),
      .k_addr0     (k_addr0),
      .k_addr1     (k_addr1),
      .k_ce0       (k_ce0),
      .k_ce1       (k_ce1),
      .k_we0       (k_we0),
      .k_we1       (k_we1),
      .k_d0        (k_d0),
      .k_d1        (k_d1),
      .k_q0        (k_q0),
      .k_q1        (k_q1),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .returnvalue (returnvalue)
`ifdef KERNEL_SHELL_PERF_EN
      ,
      .cyc_read    (cyc_read),
      .cyc_run     (cyc_run),
      .cyc_write   (cyc_write)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [HW-1:0] addr;
      logic [DW-1:0] data;
   } wexp_t;

   wexp_t         sb[$];
   logic [DW-1:0] src [0:63];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ren"},  host.read_enable, 0);
      chk({tag, "_wen"},  host.write_enable, 0);
      chk({tag, "_frd"},  host.finish_read, 0);
      chk({tag, "_fwr"},  host.finish_write, 0);
      chk({tag, "_radr"}, host.read_addr, 0);
      chk({tag, "_wadr"}, host.write_addr, 0);
      chk({tag, "_wdat"}, host.write_data, 0);
      chk({tag, "_ks"},   k_start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"},  error, 0);
      chk({tag, "_ret"},  returnvalue, 0);
      chk({tag, "_q0"},   k_q0, 0);
   endtask

   // mode 0: kernel doubles each write-back word; mode 1: dual-port collision at address 5.
   task automatic run_job(input int nr, input int nw, input int gap, input int mode,
                          input int stop_after, input logic [HW-1:0] st,
                          input logic [HW-1:0] rb, input logic [HW-1:0] wb,
                          input logic [DW-1:0] seed, input logic [DW-1:0] ret);
      int    k, cyc, fr, fw, cnt;
      wexp_t e;
      for (int j = 0; j < nr; j++) src[j] = seed + DW'(j);
      sb.delete();
      read_base = rb; write_base = wb; num_read = HW'(nr); num_write = HW'(nw); stride = st;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ren_latency", host.read_enable, 1);
      chk("busy_read", busy, 1);
      chk("err_cleared", error, 0);
      chk("ret_cleared", returnvalue, 0);

      k = 0; cyc = 0; fr = 0;
      while (k < nr && cyc < nr * (gap + 1) + 50) begin
         if (host.finish_read) fr++;
         chk("read_addr", host.read_addr, rb + 64'(k) * st);
         if (cyc % (gap + 1) == 0) begin
            host.read_ready = 1'b1;
            host.read_data  = src[k];
            if (k < nw) begin
               e.addr = wb + 64'(k) * st;
               if (mode == 0)   e.data = src[k] << 1;
               else if (k == 5) e.data = 32'hB;
               else             e.data = src[k];
               sb.push_back(e);
            end
            k++;
         end else begin
            host.read_ready = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      host.read_ready = 1'b0;
      chk("read_words", 64'(k), 64'(nr));
      chk("fin_rd_last", host.finish_read, 0);
      chk("k_start", k_start, 1);
      chk("ren_drop", host.read_enable, 0);
      chk("fin_rd_count", 64'(fr), 64'(nr - 1));

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("kstart_pulse", k_start, 0);
      chk("run_ignores_start", host.read_enable, 0);
      chk("busy_run", busy, 1);

      if (mode == 0) begin
         for (int i = 0; i < nw; i++) begin
            k_ce1 = 1'b0; k_we1 = 1'b0;
            k_ce0 = 1'b1; k_we0 = 1'b0; k_addr0 = AW'(i);
            @(negedge clk);
            chk("k_q0_read", k_q0, src[i]);
            k_ce0 = 1'b0;
            k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = AW'(i); k_d1 = src[i] << 1;
            @(negedge clk);
            chk("k_q0_hold", k_q0, src[i]);
         end
      end else begin
         k_ce0 = 1'b1; k_we0 = 1'b1; k_addr0 = AW'(5); k_d0 = 32'hA;
         k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = AW'(5); k_d1 = 32'hB;
         @(negedge clk);
      end
      k_ce0 = 1'b0; k_we0 = 1'b0; k_ce1 = 1'b0; k_we1 = 1'b0;
      k_done = 1'b1; k_ret = ret;
      @(negedge clk);
      k_done = 1'b0;
      chk("returnvalue", returnvalue, ret);
      if (nw == 0) begin
         chk("nw0_done", done, 1);
         chk("nw0_wen", host.write_enable, 0);
         return;
      end
      chk("wen_latency", host.write_enable, 1);
      chk("write_base", host.write_addr, wb);

      cnt = 0; cyc = 0; fw = 0;
      while (cnt < nw && cnt < stop_after && cyc < nw + 50) begin
         if (host.finish_write) fw++;
         if (host.write_enable) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("write_addr", host.write_addr, e.addr);
               chk("write_data", host.write_data, e.data);
            end
            host.write_ready = 1'b1;
            cnt++;
         end else begin
            host.write_ready = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      host.write_ready = 1'b0;

      if (stop_after < nw) begin
         chk("partial_words", 64'(cnt), 64'(stop_after));
         reset = 1'b1;
         @(negedge clk);
         chk_all_zero("mid_reset");
         reset = 1'b0;
         sb.delete();
         @(negedge clk);
         return;
      end
      chk("write_words", 64'(cnt), 64'(nw));
      chk("fin_wr_last", host.finish_write, 0);
      chk("done_latency", done, 1);
      chk("wen_drop", host.write_enable, 0);
      chk("busy_done", busy, 0);
      chk("fin_wr_count", 64'(fw), 64'(nw - 1));
      chk("sb_drained", 64'(sb.size()), 0);
   endtask

   task automatic reject_job(input string tag, input logic [HW-1:0] nr, input logic [HW-1:0] nw);
      num_read = nr; num_write = nw; read_base = 64'hDEAD0000; stride = 64'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_error"}, error, 1);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_no_ren"}, host.read_enable, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      read_base = '0; write_base = '0; num_read = '0; num_write = '0; stride = '0;
      host.read_ready = 1'b0; host.read_data = '0; host.write_ready = 1'b0;
      k_done = 1'b0; k_ret = '0; k_addr0 = '0; k_addr1 = '0;
      k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0; k_d0 = '0; k_d1 = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      run_job(4, 4, 0, 0, 99, 64'd4, 64'h1000, 64'h2000, 32'd1, 32'h55);
      run_job(4, 4, 2, 0, 99, 64'd8, 64'h3000, 64'h4000, 32'h100, 32'h66);

      reject_job("nr_zero", 64'd0, 64'd4);
      run_job(3, 2, 0, 0, 99, 64'd4, 64'h5000, 64'h6000, 32'h20, 32'h11);
      reject_job("nr_big", 64'd16385, 64'd4);
      reject_job("nw_big", 64'd4, 64'd16385);

      run_job(8, 8, 0, 1, 99, 64'd4, 64'hA000, 64'hB000, 32'h300, 32'h22);
      run_job(2, 0, 0, 0, 99, 64'd4, 64'hC000, 64'hD000, 32'h40, 32'h33);

      run_job(4, 4, 0, 0, 2, 64'd4, 64'h1000, 64'h2000, 32'h500, 32'h44);
      run_job(4, 4, 1, 0, 99, 64'd16, 64'hFFFF_FFFF_FFFF_FFF0, 64'h7000, 32'h600, 32'h99);

`ifdef KERNEL_SHELL_PERF_EN
      run_job(8, 2, 0, 0, 99, 64'd4, 64'h8000, 64'h9000, 32'h700, 32'h77);
      chk("cyc_read", cyc_read, 64'd8);
      chk("cyc_run", cyc_run, 64'd6);
      chk("cyc_write", cyc_write, 64'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kernel_mem_shell.md
# kernel_mem_shell

Parametrised host-side wrapper for a single HLS kernel with two external memory ports. It bulk-reads a buffer from host memory into on-chip RAM and starts the kernel. While the kernel runs, it serves the kernel's dual-port memory interface, then streams a separately sized result region back to host memory and reports done. Unlike the previous generation, it:
- re-arms on `start` without a reset;
- validates transfer lengths;
- uses independent read and write counts.

## Interface
Parameters:
- `ADDR_WID`, 14 — on-chip buffer address width; depth is `2**ADDR_WID` words.
- `DATA_WID`, 32 — word width for host data and kernel data.
- `HADDR_WID`, 64 — host address and count width.

Ports:
- `clk` — in, 1. Clock.
- `reset` — in, 1. Asynchronous, active-high.
- `start` — in, 1. Level-sampled in IDLE/DONE; begins a job.
- `read_base`, `write_base` — in, HADDR_WID. Host source and destination base addresses.
- `num_read`, `num_write` — in, HADDR_WID. Word counts for the read and write phases.
- `stride` — in, HADDR_WID. Host address increment per word.
- `read_ready` — in, 1. Host read data valid.
- `read_data` — in, DATA_WID. Host read data.
- `read_enable` — out, 1. Read request active.
- `read_addr` — out, HADDR_WID. Current host read address.
- `finish_read` — out, 1. One-cycle acknowledge of an accepted read word.
- `write_ready` — in, 1. Host accepted the write word.
- `write_enable` — out, 1. Write request active.
- `write_addr` — out, HADDR_WID. Current host write address.
- `write_data` — out, DATA_WID. Current write word.
- `finish_write` — out, 1. One-cycle acknowledge of an accepted write word.
- `k_start` — out, 1. One-cycle kernel start pulse.
- `k_done` — in, 1. Kernel completion.
- `k_ret` — in, DATA_WID. Kernel return value, sampled with `k_done`.
- `k_addr0`/`k_addr1` — in, ADDR_WID. Kernel port addresses.
- `k_ce0`/`k_ce1` — in, 1. Kernel port enables.
- `k_we0`/`k_we1` — in, 1. Kernel port write enables.
- `k_d0`/`k_d1` — in, DATA_WID. Kernel port write data.
- `k_q0`/`k_q1` — out, DATA_WID. Kernel port read data.
- `busy` — out, 1. High in READ, RUN and WRITE.
- `done` — out, 1. High in DONE.
- `error` — out, 1. Set when a job is rejected.
- `returnvalue` — out, DATA_WID. Latched `k_ret`.

## Operation
- States: IDLE, READ, RUN, WRITE, DONE.
- Reset: all outputs 0, state IDLE, counters 0. Buffer contents are undefined.
- IDLE/DONE + `start`:
  - `num_read`==0, `num_read`>2**ADDR_WID, or `num_write`>2**ADDR_WID → set `error`, go DONE, no host traffic.
  - Otherwise clear `error`, `done` and `returnvalue`; load `read_addr`=`read_base`; raise `read_enable`; go READ.
  - `num_write`==0 is legal: WRITE is skipped.
- READ:
  - Each cycle with `read_ready`=1 stores `read_data` at index `rcnt` and pulses `finish_read` the next cycle.
  - Same cycle, `read_addr` += `stride` and `rcnt`++.
  - On the last word: drop `read_enable`, pulse `k_start`, go RUN. No `finish_read` pulse on the last word.
- RUN:
  - Ports 0 and 1 are serviced every cycle.
  - `ce`&`we` writes `d` to `addr`.
  - `ce`&!`we` registers `mem[addr]` onto `q` with 1-cycle latency.
  - `q` holds its value when `ce`=0.
  - Same-address writes on both ports in one cycle: port 1 wins.
  - Read of an address written the same cycle on the other port returns old data (read-first).
  - `k_done`: latch `k_ret` into `returnvalue`.
    - `num_write`>0: go WRITE with `write_addr`=`write_base`, `write_data`=`mem[0]`, `write_enable`=1.
    - `num_write`==0: go DONE.
- WRITE:
  - Each cycle with `write_ready`=1 pulses `finish_write` the next cycle, `write_addr` += `stride`, and loads `write_data`=`mem[wcnt+1]`.
  - On the last word: drop `write_enable`, go DONE. No `finish_write` pulse on the last word.
- DONE: `done`=1 until the next accepted `start`.
- `start` outside IDLE/DONE is ignored.

## Timing
- `start` → `read_enable` high: 1 cycle.
- Last read word → `k_start` pulse: 1 cycle.
- `k_done` → `write_enable`: 1 cycle.
- Last `write_ready` → `done`: 1 cycle.
- Host address arithmetic is modulo 2**HADDR_WID; wrap-around is not flagged.
- Reset asserted mid-job: immediate return to IDLE, all outputs 0. The kernel is not notified; it must share `reset`.

## Configuration
- `KERNEL_SHELL_PERF_EN` defined: adds outputs `cyc_read`, `cyc_run`, `cyc_write` (each HADDR_WID).
  - Each counts clocks spent in its state.
  - All three clear on an accepted `start` and hold in DONE.
- Undefined: these ports and counters are absent; no other behaviour changes.

## Structure
- Package `kernel_shell_pkg`: state enum `shell_state_t`, default widths, and error-code constant.
- Sub-module `shell_dpram`: 2-port, `2**ADDR_WID` × DATA_WID, registered read, port-1-wins write priority.
- The host port muxes into `shell_dpram` port 0 during READ/WRITE.

## Test plan
- `num_read`=4, `num_write`=4, `stride`=4, kernel stub doubles each word; data 1,2,3,4 → writes 2,4,6,8 at `write_base`+0,4,8,12; `done`=1; `returnvalue`=stub value.
- `read_ready` gapped (1 cycle on, 2 off) → exactly `num_read` words stored; `finish_read` pulses=3; `read_addr` advances only on ready.
- `num_read`=0 → `error`=1, `done`=1, `read_enable` never asserted. A second `start` with valid counts → `error` cleared and job completes.
- Kernel writes addr 5 on both ports in one cycle (`d0`=0xA, `d1`=0xB) → write-back word 5 = 0xB.
- Reset asserted during WRITE after 2 words → all outputs 0 next edge. A subsequent full job passes.
- `KERNEL_SHELL_PERF_EN`: `num_read`=8 with `read_ready` always high → `cyc_read`=8.
